alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Upstream control and operand stage for the ALU output mux. Accepts an opcode and two operands over a valid/ready handshake and registers the operands toward the logic, add and sub units. Drives the 7-bit one-hot select that the output mux consumes. Contains the multi-cycle shift-add multiplier that produces the mux's mult input.

Parameters:
WIDTH, 8, operand/result width in bits
NUM_OPS, 7, one-hot select width; fixed at 7 (AND, OR, XOR, NOT, ADD, SUB, MULT)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid && in_ready
opcode  input  3  0 AND, 1 OR, 2 XOR, 3 NOT(A), 4 ADD, 5 SUB, 6 MULT, 7 illegal
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op_a  output  WIDTH  registered A to the functional units
op_b  output  WIDTH  registered B to the functional units
sel  output  NUM_OPS  one-hot select to the output mux
mult_result  output  WIDTH  low WIDTH bits of A*B
out_valid  output  1  sel/op_a/op_b/mult_result are valid for the mux
out_ready  input  1  consumer took the result
err_opcode  output  1  current result is for an illegal opcode

Behaviour:
- Reset (async assert, rst_n=0): state IDLE; op_a, op_b, sel, mult_result, out_valid, err_opcode all 0; internal counter and accumulator 0. Reset takes effect immediately, including mid-multiply; the partial product is discarded.
- in_ready = (state==IDLE), decoded from the state register only; no combinational path from out_ready.
- IDLE, on accept:
  - latch op_a=a, op_b=b.
  - opcode 0..5: sel = 1<<opcode; next state HOLD.
  - opcode 6: sel = 7'b1000000; acc=0, mcand=a, mplier=b, cnt=0; next state EXEC.
  - opcode 7: sel=0, err_opcode=1; next state HOLD.
- EXEC: one iteration per cycle: if mplier[0], acc=acc+mcand (mod 2^WIDTH); mcand<<=1; mplier>>=1; cnt++. After iteration WIDTH-1, mult_result=acc_final and next state is HOLD. No early termination; latency is fixed.
- HOLD: out_valid=1. sel, op_a, op_b, mult_result and err_opcode are held stable while out_ready=0. On out_ready=1: next state IDLE, out_valid=0, sel=0, err_opcode=0. op_a, op_b and mult_result keep their values.
- Latency (accept edge = E0):
  - non-mult and illegal opcodes: out_valid=1 from the cycle after E0.
  - MULT: out_valid=1 from the cycle after edge E0+WIDTH.
- Throughput: at most one op per 2 cycles. There is no accept in the HOLD cycle where out_ready=1, because in_ready=0 during HOLD.
- sel is always one-hot or zero; it is never multi-hot.
- in_valid outside IDLE is ignored. Inputs are sampled only on an accept.
- Arithmetic: ADD/SUB are computed downstream from op_a/op_b. mult_result is truncated to WIDTH bits.

Optional Feature:
ALU_MULT_OVF_EN:
- Defined: the accumulator is 2*WIDTH bits and mcand is 2*WIDTH bits. An extra output port mult_ovf (1 bit, reset 0) is set in HOLD for a MULT when product[2*WIDTH-1:WIDTH] != 0. It is cleared together with out_valid.
- Undefined: the port is absent and the accumulator is WIDTH bits.

Test Plan:
- ADD a=0x35 b=0x12 accepted at E0 -> cycle after E0: out_valid=1, sel=7'b0010000, op_a=0x35, op_b=0x12, in_ready=0; out_ready=1 -> next cycle in_ready=1, sel=0.
- MULT a=13 b=11 -> out_valid rises exactly 8 cycles after the cycle following E0, with mult_result=0x8F and sel=7'b1000000. With ALU_MULT_OVF_EN: mult_ovf=0.
- MULT a=0x20 b=0x10 -> mult_result=0x00. With ALU_MULT_OVF_EN: mult_ovf=1.
- opcode=7 a=0xFF b=0x01 -> next cycle out_valid=1, err_opcode=1, sel=0.
- XOR result with out_ready held 0 for 5 cycles while in_valid=1 with new data -> sel=7'b0000100, op_a and op_b stable, in_ready=0 throughout; the new request is accepted only after the HOLD exit.
- rst_n pulsed low during EXEC iteration 4 of MULT 0xFF*0xFF -> all outputs 0 asynchronously; after release in_ready=1 and a following AND 0xF0&0x3C gives sel=7'b0000001, op_a=0xF0, op_b=0x3C.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: request/result bundle between the ALU operand stage
// and its surroundings. The master side issues requests and consumes
// results; the slave side is the sequencer itself.
// With ALU_MULT_OVF_EN defined the bundle also carries mult_ovf.
interface alu_op_sequencer_if #(
    parameter int WIDTH   = 8,
    parameter int NUM_OPS = 7
);
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         opcode;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [NUM_OPS-1:0] sel;
    logic [WIDTH-1:0]   mult_result;
    logic               out_valid;
    logic               out_ready;
    logic               err_opcode;
`ifdef ALU_MULT_OVF_EN
    logic               mult_ovf;
`endif

`ifdef ALU_MULT_OVF_EN
    modport master (
        output in_valid, opcode, a, b, out_ready,
        input  in_ready, op_a, op_b, sel, mult_result, out_valid, err_opcode, mult_ovf
    );
    modport slave (
        input  in_valid, opcode, a, b, out_ready,
        output in_ready, op_a, op_b, sel, mult_result, out_valid, err_opcode, mult_ovf
    );
`else
    modport master (
        output in_valid, opcode, a, b, out_ready,
        input  in_ready, op_a, op_b, sel, mult_result, out_valid, err_opcode
    );
    modport slave (
        input  in_valid, opcode, a, b, out_ready,
        output in_ready, op_a, op_b, sel, mult_result, out_valid, err_opcode
    );
`endif
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts an opcode plus two operands, registers the
// operands for the logic/add/sub units, drives the one-hot output-mux
// select and runs a fixed-latency shift-add multiplier for MULT.
// Optional feature macro: ALU_MULT_OVF_EN (double-width accumulator and a
// mult_ovf flag for products that do not fit in WIDTH bits).
module alu_op_sequencer #(
    parameter int WIDTH   = 8,
    parameter int NUM_OPS = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_op_sequencer_if.slave bus
);

`ifdef ALU_MULT_OVF_EN
    localparam int ACC_W = 2 * WIDTH;
`else
    localparam int ACC_W = WIDTH;
`endif
    localparam int             CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q,       state_d;
    logic [WIDTH-1:0]   op_a_q,        op_a_d;
    logic [WIDTH-1:0]   op_b_q,        op_b_d;
    logic [NUM_OPS-1:0] sel_q,         sel_d;
    logic [WIDTH-1:0]   mult_result_q, mult_result_d;
    logic               out_valid_q,   out_valid_d;
    logic               err_opcode_q,  err_opcode_d;
    logic [ACC_W-1:0]   acc_q,         acc_d;
    logic [ACC_W-1:0]   mcand_q,       mcand_d;
    logic [WIDTH-1:0]   mplier_q,      mplier_d;
    logic [CNT_W-1:0]   cnt_q,         cnt_d;
    logic [ACC_W-1:0]   acc_sum;
`ifdef ALU_MULT_OVF_EN
    logic               mult_ovf_q,    mult_ovf_d;
`endif

    // Next-state and next-output logic for the IDLE -> (EXEC) -> HOLD flow.
    always_comb begin
        state_d       = state_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        sel_d         = sel_q;
        mult_result_d = mult_result_q;
        out_valid_d   = out_valid_q;
        err_opcode_d  = err_opcode_q;
        acc_d         = acc_q;
        mcand_d       = mcand_q;
        mplier_d      = mplier_q;
        cnt_d         = cnt_q;
`ifdef ALU_MULT_OVF_EN
        mult_ovf_d    = mult_ovf_q;
`endif
        acc_sum       = acc_q + (mplier_q[0] ? mcand_q : '0);

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_a_d = bus.a;
                    op_b_d = bus.b;
                    case (bus.opcode)
                        3'd6: begin
                            sel_d    = NUM_OPS'(1) << 6;
                            acc_d    = '0;
                            mcand_d  = ACC_W'(bus.a);
                            mplier_d = bus.b;
                            cnt_d    = '0;
                            state_d  = EXEC;
                        end
                        3'd7: begin
                            sel_d        = '0;
                            err_opcode_d = 1'b1;
                            out_valid_d  = 1'b1;
                            state_d      = HOLD;
                        end
                        default: begin
                            sel_d       = NUM_OPS'(1) << bus.opcode;
                            out_valid_d = 1'b1;
                            state_d     = HOLD;
                        end
                    endcase
                end
            end
            EXEC: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    mult_result_d = acc_sum[WIDTH-1:0];
                    out_valid_d   = 1'b1;
                    state_d       = HOLD;
`ifdef ALU_MULT_OVF_EN
                    mult_ovf_d    = (acc_sum[ACC_W-1:WIDTH] != '0);
`endif
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d  = 1'b0;
                    sel_d        = '0;
                    err_opcode_d = 1'b0;
                    state_d      = IDLE;
`ifdef ALU_MULT_OVF_EN
                    mult_ovf_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state and registered outputs; async reset discards any partial product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            op_a_q        <= '0;
            op_b_q        <= '0;
            sel_q         <= '0;
            mult_result_q <= '0;
            out_valid_q   <= 1'b0;
            err_opcode_q  <= 1'b0;
            acc_q         <= '0;
            mcand_q       <= '0;
            mplier_q      <= '0;
            cnt_q         <= '0;
`ifdef ALU_MULT_OVF_EN
            mult_ovf_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            sel_q         <= sel_d;
            mult_result_q <= mult_result_d;
            out_valid_q   <= out_valid_d;
            err_opcode_q  <= err_opcode_d;
            acc_q         <= acc_d;
            mcand_q       <= mcand_d;
            mplier_q      <= mplier_d;
            cnt_q         <= cnt_d;
`ifdef ALU_MULT_OVF_EN
            mult_ovf_q    <= mult_ovf_d;
`endif
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.op_a        = op_a_q;
    assign bus.op_b        = op_b_q;
    assign bus.sel         = sel_q;
    assign bus.mult_result = mult_result_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.err_opcode  = err_opcode_q;
`ifdef ALU_MULT_OVF_EN
    assign bus.mult_ovf    = mult_ovf_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed scoreboard bench for alu_op_sequencer.
// Expected results are pushed when a request is issued and popped when the
// DUT raises out_valid. Honours ALU_MULT_OVF_EN for the mult_ovf checks.
module tb_alu_op_sequencer;

    localparam int WIDTH   = 8;
    localparam int NUM_OPS = 7;

    typedef struct {
        logic [NUM_OPS-1:0] sel;
        logic [WIDTH-1:0]   op_a;
        logic [WIDTH-1:0]   op_b;
        logic [WIDTH-1:0]   mres;
        logic               err;
        logic               ovf;
        int                 lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    logic [WIDTH-1:0] last_mult = '0;

    alu_op_sequencer_if #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS)) bus ();

    alu_op_sequencer #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Free-running clock, rising edge active.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one request, wait (bounded) for in_ready, record the expected result.
    task automatic applyStimulus(input logic [2:0] opc, input logic [WIDTH-1:0] av,
                                 input logic [WIDTH-1:0] bv);
        exp_t e;
        logic [2*WIDTH-1:0] prod;
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.opcode   = opc;
        bus.a        = av;
        bus.b        = bv;
        while (bus.in_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        if (waited >= 50) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        prod   = (2*WIDTH)'(av) * (2*WIDTH)'(bv);
        e.sel  = (opc == 3'd7) ? '0 : (NUM_OPS'(1) << opc);
        e.op_a = av;
        e.op_b = bv;
        e.err  = (opc == 3'd7);
        e.ovf  = 1'b0;
        e.lat  = 1;
        if (opc == 3'd6) begin
            last_mult = prod[WIDTH-1:0];
            e.ovf     = (prod[2*WIDTH-1:WIDTH] != '0);
            e.lat     = WIDTH + 1;
        end
        e.mres = last_mult;
        sb_q.push_back(e);
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Wait for out_valid, compare against the scoreboard, hold, then release.
    task automatic checkOutput(input string tag, input int hold);
        exp_t e;
        int cyc = 1;
        while (bus.out_valid !== 1'b1 && cyc < 50) begin
            tick();
            cyc++;
        end
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        check({tag, "_latency"},   32'(cyc),             32'(e.lat));
        check({tag, "_out_valid"}, 32'(bus.out_valid),   32'd1);
        check({tag, "_in_ready"},  32'(bus.in_ready),    32'd0);
        check({tag, "_sel"},       32'(bus.sel),         32'(e.sel));
        check({tag, "_op_a"},      32'(bus.op_a),        32'(e.op_a));
        check({tag, "_op_b"},      32'(bus.op_b),        32'(e.op_b));
        check({tag, "_mult"},      32'(bus.mult_result), 32'(e.mres));
        check({tag, "_err"},       32'(bus.err_opcode),  32'(e.err));
`ifdef ALU_MULT_OVF_EN
        check({tag, "_ovf"},       32'(bus.mult_ovf),    32'(e.ovf));
`endif
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_hold_ready"}, 32'(bus.in_ready),  32'd0);
            check({tag, "_hold_sel"},   32'(bus.sel),       32'(e.sel));
            check({tag, "_hold_op_a"},  32'(bus.op_a),      32'(e.op_a));
            check({tag, "_hold_op_b"},  32'(bus.op_b),      32'(e.op_b));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_rel_valid"}, 32'(bus.out_valid),   32'd0);
        check({tag, "_rel_ready"}, 32'(bus.in_ready),    32'd1);
        check({tag, "_rel_sel"},   32'(bus.sel),         32'd0);
        check({tag, "_rel_err"},   32'(bus.err_opcode),  32'd0);
        check({tag, "_rel_op_a"},  32'(bus.op_a),        32'(e.op_a));
        check({tag, "_rel_mult"},  32'(bus.mult_result), 32'(e.mres));
`ifdef ALU_MULT_OVF_EN
        check({tag, "_rel_ovf"},   32'(bus.mult_ovf),    32'd0);
`endif
    endtask

    // Every output must sit at its reset value.
    task automatic checkResetState(input string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready),    32'd1);
        check({tag, "_out_valid"}, 32'(bus.out_valid),   32'd0);
        check({tag, "_sel"},       32'(bus.sel),         32'd0);
        check({tag, "_op_a"},      32'(bus.op_a),        32'd0);
        check({tag, "_op_b"},      32'(bus.op_b),        32'd0);
        check({tag, "_mult"},      32'(bus.mult_result), 32'd0);
        check({tag, "_err"},       32'(bus.err_opcode),  32'd0);
`ifdef ALU_MULT_OVF_EN
        check({tag, "_ovf"},       32'(bus.mult_ovf),    32'd0);
`endif
    endtask

    // Directed sequence.
    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.opcode    = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        checkResetState("reset");
        rst_n = 1'b1;
        tick();

        $display("[TB] ADD");
        applyStimulus(3'd4, 8'h35, 8'h12);
        checkOutput("add", 0);

        $display("[TB] MULT 13*11");
        applyStimulus(3'd6, 8'd13, 8'd11);
        checkOutput("mult_13x11", 0);

        $display("[TB] MULT 0x20*0x10");
        applyStimulus(3'd6, 8'h20, 8'h10);
        checkOutput("mult_ovf", 0);

        $display("[TB] illegal opcode");
        applyStimulus(3'd7, 8'hFF, 8'h01);
        checkOutput("illegal", 0);

        $display("[TB] XOR with back-pressure and pending request");
        applyStimulus(3'd2, 8'hA5, 8'h3C);
        bus.in_valid = 1'b1;
        bus.opcode   = 3'd1;
        bus.a        = 8'h0F;
        bus.b        = 8'hC0;
        checkOutput("xor_hold", 5);
        applyStimulus(3'd1, 8'h0F, 8'hC0);
        checkOutput("or_pending", 0);

        $display("[TB] MULT 3*5");
        applyStimulus(3'd6, 8'd3, 8'd5);
        checkOutput("mult_3x5", 0);

        $display("[TB] reset during MULT 0xFF*0xFF");
        applyStimulus(3'd6, 8'hFF, 8'hFF);
        for (int i = 0; i < 4; i++) tick();
        check("mid_mult_sel", 32'(bus.sel), 32'h40);
        #2 rst_n = 1'b0;
        #1;
        checkResetState("async_reset");
        sb_q.delete();
        last_mult = '0;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_in_ready", 32'(bus.in_ready), 32'd1);

        $display("[TB] AND after reset");
        applyStimulus(3'd0, 8'hF0, 8'h3C);
        checkOutput("and_after_reset", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
